// File: rtl/alu_mdu_pkg.sv
// Shared op codes, exception classes and MDU timing defaults
// for the execute-stage ALU and multiply/divide unit.
package alu_mdu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLT  = 5'd9,
        ALU_SLTU = 5'd10,
        ALU_LUI  = 5'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic [2:0] {
        FIND_NONE = 3'd0,
        FIND_OV   = 3'd1,
        FIND_ADEL = 3'd2,
        FIND_ADES = 3'd3
    } alu_find_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic ov;
        logic adel;
        logic ades;
    } alu_exc_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic md_is_arith(input logic [3:0] op);
        return op == MD_MULT || op == MD_MULTU ||
               op == MD_DIV  || op == MD_DIVU;
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/alu_mdu_mdu_core.sv
// Multiply/divide sequencer with operand latches and HI/LO.
// Results land after a fixed busy period per operation class.
module mdu_core
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       md_op,
    input  logic             md_start,
    input  logic             md_cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e     state;
    mdu_state_e     state_nxt;
    logic [CW-1:0]  cnt;
    logic [3:0]     op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic req;
    logic accept;
    logic done;

    assign req    = md_start && !md_cancel;
    assign accept = state == MDU_IDLE && req && md_is_arith(md_op);
    assign done   = state == MDU_RUN && cnt == CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) state <= MDU_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MDU_IDLE: if (accept) state_nxt = MDU_RUN;
            MDU_RUN:  if (done)   state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MDU_RUN);
    end

    // Full-width product: sign- or zero-extend, keep low 2*WIDTH bits.
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] prod;
    logic               sgn;

    assign sgn   = (op_q == MD_MULT) || (op_q == MD_DIV);
    assign mul_a = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    assign mul_b = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    assign prod  = mul_a * mul_b;

    // Signed divide via magnitudes; MIN/-1 wraps back to MIN, rem 0.
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign neg_a = sgn & a_q[WIDTH-1];
    assign neg_b = sgn & b_q[WIDTH-1];
    assign mag_a = neg_a ? -a_q : a_q;
    assign mag_b = neg_b ? -b_q : b_q;
    assign dvs   = (mag_b == '0) ? WIDTH'(1) : mag_b;
    assign uq    = mag_a / dvs;
    assign ur    = mag_a % dvs;
    assign quo   = (neg_a ^ neg_b) ? -uq : uq;
    assign rem   = neg_a ? -ur : ur;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             wr_ok;

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        wr_ok  = 1'b1;
        if (md_is_div(op_q)) begin
            res_hi = rem;
            res_lo = quo;
            wr_ok  = (b_q != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= MD_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (state == MDU_IDLE) begin
            if (accept) begin
                op_q <= md_op;
                a_q  <= a;
                b_q  <= b;
                cnt  <= md_is_div(md_op) ? CW'(DIV_CYCLES)
                                         : CW'(MULT_CYCLES);
            end else if (req && md_op == MD_MTHI) begin
                hi <= a;
            end else if (req && md_op == MD_MTLO) begin
                lo <= a;
            end
        end else if (done) begin
            cnt <= '0;
            if (wr_ok) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with overflow exception routing, wrapping
// the iterative multiply/divide unit and its HI/LO registers.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHAMT_W     = $clog2(WIDTH),
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [SHAMT_W-1:0] in3,
    input  logic [2:0]         alu_find,
    output logic [WIDTH-1:0]   ans,
    output logic               equal_zero,
    output logic               e_ov,
    output logic               e_adel,
    output logic               e_ades,
    input  logic [3:0]         md_op,
    input  logic               md_start,
    input  logic               md_cancel,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] dif_x;
    logic           ov;
    alu_exc_t       exc;

    assign sum_x = {in1[WIDTH-1], in1} + {in2[WIDTH-1], in2};
    assign dif_x = {in1[WIDTH-1], in1} - {in2[WIDTH-1], in2};

    always_comb begin
        ans = '0;
        ov  = 1'b0;
        case (op)
            ALU_ADD: begin
                ans = sum_x[WIDTH-1:0];
                ov  = sum_x[WIDTH] ^ sum_x[WIDTH-1];
            end
            ALU_SUB: begin
                ans = dif_x[WIDTH-1:0];
                ov  = dif_x[WIDTH] ^ dif_x[WIDTH-1];
            end
            ALU_AND:  ans = in1 & in2;
            ALU_OR:   ans = in1 | in2;
            ALU_XOR:  ans = in1 ^ in2;
            ALU_NOR:  ans = ~(in1 | in2);
            ALU_SLL:  ans = in2 << in3;
            ALU_SRL:  ans = in2 >> in3;
            ALU_SRA:  ans = $unsigned($signed(in2) >>> in3);
            ALU_SLT:  ans = WIDTH'($signed(in1) < $signed(in2));
            ALU_SLTU: ans = WIDTH'(in1 < in2);
            ALU_LUI:  ans = in2 << (WIDTH / 2);
            default:  ans = '0;
        endcase
    end

    always_comb begin
        exc = '0;
        unique case (1'b1)
            alu_find == FIND_OV:   exc.ov   = ov;
            alu_find == FIND_ADEL: exc.adel = ov;
            alu_find == FIND_ADES: exc.ades = ov;
            default:               exc      = '0;
        endcase
    end

    assign e_ov       = exc.ov;
    assign e_adel     = exc.adel;
    assign e_ades     = exc.ades;
    assign equal_zero = (ans == '0);

    mdu_core #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu (
        .clk       (clk),
        .reset     (reset),
        .md_op     (md_op),
        .md_start  (md_start),
        .md_cancel (md_cancel),
        .a         (in1),
        .b         (in2),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: ALU flags plus MDU timing,
// results, cancel, interference and mid-run reset.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  in3;
    logic [2:0]  alu_find;
    logic [31:0] ans;
    logic        equal_zero;
    logic        e_ov;
    logic        e_adel;
    logic        e_ades;
    logic [3:0]  md_op;
    logic        md_start;
    logic        md_cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mdu dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .alu_find   (alu_find),
        .ans        (ans),
        .equal_zero (equal_zero),
        .e_ov       (e_ov),
        .e_adel     (e_adel),
        .e_ades     (e_ades),
        .md_op      (md_op),
        .md_start   (md_start),
        .md_cancel  (md_cancel),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input string tag, input logic [3:0] mop,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n);
        md_op    = mop;
        in1      = a;
        in2      = b;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        md_op    = MD_NONE;
        for (int c = 1; c <= n; c++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        op        = ALU_ADD;
        in1       = '0;
        in2       = '0;
        in3       = '0;
        alu_find  = FIND_NONE;
        md_op     = MD_NONE;
        md_start  = 1'b0;
        md_cancel = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        op = ALU_ADD; in1 = 32'h7FFF_FFFF; in2 = 32'h1;
        alu_find = FIND_OV; #1;
        check("add_ans", ans, 32'h8000_0000);
        check("add_flags", {29'd0, e_ov, e_adel, e_ades}, 32'b100);
        alu_find = FIND_ADEL; #1;
        check("adel_flags", {29'd0, e_ov, e_adel, e_ades}, 32'b010);
        alu_find = FIND_ADES; #1;
        check("ades_flags", {29'd0, e_ov, e_adel, e_ades}, 32'b001);
        op = ALU_AND; alu_find = FIND_OV; #1;
        check("and_ans", ans, 32'h1);
        check("and_flags", {29'd0, e_ov, e_adel, e_ades}, 32'b000);
        op = ALU_SUB; in1 = 32'h8000_0000; in2 = 32'h1; #1;
        check("sub_ans", ans, 32'h7FFF_FFFF);
        check("sub_ov", 32'(e_ov), 32'd1);
        op = ALU_ADD; in1 = 32'h5; in2 = 32'hFFFF_FFFB; #1;
        check("add_zero", ans, 32'h0);
        check("add_eqz", 32'(equal_zero), 32'd1);
        check("add_noov", 32'(e_ov), 32'd0);
        op = ALU_SLT; in1 = 32'hFFFF_FFFF; in2 = 32'h1; #1;
        check("slt", ans, 32'h1);
        op = ALU_SLTU; #1;
        check("sltu", ans, 32'h0);
        op = ALU_SRA; in2 = 32'h8000_0000; in3 = 5'd4; #1;
        check("sra", ans, 32'hF800_0000);
        op = ALU_SRL; #1;
        check("srl", ans, 32'h0800_0000);
        op = ALU_SLL; in2 = 32'h0000_0003; #1;
        check("sll", ans, 32'h0000_0030);
        op = ALU_NOR; in1 = 32'h0F0F_0000; in2 = 32'h0000_00FF; #1;
        check("nor", ans, 32'hF0F0_FF00);
        op = ALU_LUI; in2 = 32'h0000_1234; #1;
        check("lui", ans, 32'h1234_0000);
        op = 5'd31; #1;
        check("unknown", ans, 32'h0);
        alu_find = FIND_NONE;

        run_md("mult", MD_MULT, 32'hFFFF_FFFD, 32'h5, 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        run_md("multu", MD_MULTU, 32'hFFFF_FFFD, 32'h5, 5);
        check("multu_hi", hi, 32'h0000_0004);
        check("multu_lo", lo, 32'hFFFF_FFF1);
        run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'h2, 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_md("divmin", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'h0);

        md_op = MD_MTHI; in1 = 32'h11; md_start = 1'b1;
        tick();
        md_op = MD_MTLO; in1 = 32'h22;
        tick();
        md_start = 1'b0; md_op = MD_NONE;
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        check("mt_busy", 32'(busy), 32'd0);
        run_md("divz", MD_DIVU, 32'h7, 32'h0, 10);
        check("divz_hi", hi, 32'h11);
        check("divz_lo", lo, 32'h22);

        md_op = MD_DIV; in1 = 32'd100; in2 = 32'd7; md_start = 1'b1;
        tick();
        md_start = 1'b0; md_op = MD_NONE;
        for (int c = 1; c <= 10; c++) begin
            check("intf_busy", 32'(busy), 32'd1);
            if (c == 2) begin
                md_op = MD_MULT; in1 = 32'd9; in2 = 32'd9; md_start = 1'b1;
            end
            if (c == 3) begin
                md_op = MD_MTHI; in1 = 32'hDEAD;
            end
            if (c == 4) begin
                md_start = 1'b0; md_op = MD_NONE;
            end
            if (c == 5) check("intf_mthi", hi, 32'h11);
            tick();
        end
        check("intf_done", 32'(busy), 32'd0);
        check("intf_lo", lo, 32'd14);
        check("intf_hi", hi, 32'd2);
        tick();
        check("intf_idle", 32'(busy), 32'd0);

        md_op = MD_MULT; in1 = 32'd3; in2 = 32'd4;
        md_start = 1'b1; md_cancel = 1'b1;
        tick();
        md_start = 1'b0; md_cancel = 1'b0; md_op = MD_NONE;
        check("cancel_busy", 32'(busy), 32'd0);
        tick();
        check("cancel_busy2", 32'(busy), 32'd0);
        check("cancel_hi", hi, 32'd2);
        check("cancel_lo", lo, 32'd14);

        md_op = MD_MTLO; in1 = 32'hABCD; md_start = 1'b1;
        tick();
        md_start = 1'b0; md_op = MD_NONE;
        check("mtlo2", lo, 32'hABCD);

        md_op = MD_DIV; in1 = 32'd50; in2 = 32'd3; md_start = 1'b1;
        tick();
        md_start = 1'b0; md_op = MD_NONE;
        check("rdiv_c1", 32'(busy), 32'd1);
        tick();
        check("rdiv_c2", 32'(busy), 32'd1);
        tick();
        check("rdiv_c3", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rdiv_busy", 32'(busy), 32'd0);
        check("rdiv_hi", hi, 32'h0);
        check("rdiv_lo", lo, 32'h0);
        run_md("m23", MD_MULT, 32'd2, 32'd3, 5);
        check("m23_lo", lo, 32'd6);
        check("m23_hi", hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
